// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID pipeline register as a 2-entry skid buffer with valid/ready on both sides
module if_id_skid_reg #(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_instruction,
    input  logic [PC_WIDTH-1:0]   in_pc_plus4,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_instruction,
    output logic [PC_WIDTH-1:0]   out_pc_plus4,
    output logic [15:0]           out_imm16,
    output logic [1:0]            occupancy
);
    logic                  main_valid_q, main_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [INST_WIDTH-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
    logic [PC_WIDTH-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic                  accept, consume;

    assign in_ready        = !skid_valid_q;
    assign out_valid       = main_valid_q;
    assign out_instruction = main_inst_q;
    assign out_pc_plus4    = main_pc_q;
    assign out_imm16       = main_inst_q[15:0];
    assign occupancy       = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign accept          = in_valid & in_ready;
    assign consume         = main_valid_q & out_ready;

    // Next-state: flush wins, then EMPTY / ONE / FULL transitions keyed off the valid bits
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_inst_d  = main_inst_q;
        main_pc_d    = main_pc_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        if (Flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_inst_d  = in_instruction;
                main_pc_d    = in_pc_plus4;
            end
        end else if (!skid_valid_q) begin
            if (accept && consume) begin
                main_inst_d = in_instruction;
                main_pc_d   = in_pc_plus4;
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_inst_d  = in_instruction;
                skid_pc_d    = in_pc_plus4;
            end else if (consume) begin
                main_valid_d = 1'b0;
            end
        end else if (consume) begin
            main_inst_d  = skid_inst_q;
            main_pc_d    = skid_pc_q;
            skid_valid_d = 1'b0;
        end
    end

    // State registers; data resets to zero (NOP) but is left untouched by flush
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_inst_q  <= '0;
            main_pc_q    <= '0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_inst_q  <= main_inst_d;
            main_pc_q    <= main_pc_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: directed and randomised checks of the IF/ID skid register
module tb_if_id_skid_reg;
    logic        Clk = 1'b0;
    logic        Reset, Flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instruction, in_pc_plus4, out_instruction, out_pc_plus4;
    logic [15:0] out_imm16;
    logic [1:0]  occupancy;
    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] p;
    } ent_t;

    if_id_skid_reg #(.INST_WIDTH(32), .PC_WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc_plus4(in_pc_plus4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc_plus4(out_pc_plus4),
        .out_imm16(out_imm16), .occupancy(occupancy)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] i, input logic [31:0] p);
        in_valid = v;
        in_instruction = i;
        in_pc_plus4 = p;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        #2;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_instruction !== 32'h0)
            $display("FAIL reset_init: out_valid=%b in_ready=%b occ=%0d inst=%h, want 0 1 0 00000000", out_valid, in_ready, occupancy, out_instruction);
        else passed++;
        @(negedge Clk); Reset = 1'b0;
        offer(1'b1, 32'h1111_2222, 32'h4);
        tick;
        offer(1'b1, 32'h3333_4444, 32'h8);
        tick;
        offer(1'b0, 32'h0, 32'h0);
        total++; if (occupancy !== 2'd2)
            $display("FAIL reset_prefill: occ=%0d want 2", occupancy);
        else passed++;
        #2 Reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0)
            $display("FAIL reset_async: out_valid=%b in_ready=%b occ=%0d, want 0 1 0", out_valid, in_ready, occupancy);
        else passed++;
        @(negedge Clk); Reset = 1'b0;
        tick;
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        offer(1'b1, 32'h2008_FFFC, 32'h0000_0004);
        tick;
        total++; if (out_valid !== 1'b1 || out_instruction !== 32'h2008_FFFC || out_imm16 !== 16'hFFFC || occupancy !== 2'd1)
            $display("FAIL stream_w0: v=%b inst=%h imm=%h occ=%0d, want 1 2008fffc fffc 1", out_valid, out_instruction, out_imm16, occupancy);
        else passed++;
        offer(1'b1, 32'h8C09_0004, 32'h0000_0008);
        tick;
        total++; if (out_instruction !== 32'h8C09_0004 || out_imm16 !== 16'h0004 || out_pc_plus4 !== 32'h8 || occupancy !== 2'd1)
            $display("FAIL stream_w1: inst=%h imm=%h pc=%h occ=%0d, want 8c090004 0004 00000008 1", out_instruction, out_imm16, out_pc_plus4, occupancy);
        else passed++;
        offer(1'b0, 32'h0, 32'h0);
        tick;
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL stream_drain: v=%b occ=%0d, want 0 0", out_valid, occupancy);
        else passed++;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        offer(1'b1, 32'hAAAA_0001, 32'h10);
        tick;
        offer(1'b1, 32'hBBBB_0002, 32'h14);
        tick;
        total++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_instruction !== 32'hAAAA_0001)
            $display("FAIL bp_full: occ=%0d rdy=%b inst=%h, want 2 0 aaaa0001", occupancy, in_ready, out_instruction);
        else passed++;
        offer(1'b1, 32'hCCCC_0003, 32'h18);
        tick;
        total++; if (occupancy !== 2'd2 || out_instruction !== 32'hAAAA_0001 || out_imm16 !== 16'h0001 || out_pc_plus4 !== 32'h10)
            $display("FAIL bp_hold: occ=%0d inst=%h imm=%h pc=%h, want 2 aaaa0001 0001 00000010", occupancy, out_instruction, out_imm16, out_pc_plus4);
        else passed++;
        out_ready = 1'b1;
        tick;
        total++; if (out_instruction !== 32'hBBBB_0002 || occupancy !== 2'd1 || in_ready !== 1'b1)
            $display("FAIL bp_b: inst=%h occ=%0d rdy=%b, want bbbb0002 1 1", out_instruction, occupancy, in_ready);
        else passed++;
        tick;
        offer(1'b0, 32'h0, 32'h0);
        total++; if (out_instruction !== 32'hCCCC_0003 || out_pc_plus4 !== 32'h18 || occupancy !== 2'd1)
            $display("FAIL bp_c: inst=%h pc=%h occ=%0d, want cccc0003 00000018 1", out_instruction, out_pc_plus4, occupancy);
        else passed++;
        tick;
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL bp_drain: v=%b occ=%0d, want 0 0", out_valid, occupancy);
        else passed++;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        offer(1'b1, 32'h1234_5678, 32'h20);
        tick;
        offer(1'b1, 32'h9ABC_DEF0, 32'h24);
        tick;
        offer(1'b1, 32'hDEAD_BEEF, 32'h28);
        Flush = 1'b1;
        tick;
        Flush = 1'b0;
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_full: occ=%0d v=%b rdy=%b, want 0 0 1", occupancy, out_valid, in_ready);
        else passed++;
        offer(1'b0, 32'h0, 32'h0);
        tick;
        total++; if (occupancy !== 2'd0 || out_instruction !== 32'h1234_5678)
            $display("FAIL flush_drop: occ=%0d inst=%h, want 0 12345678", occupancy, out_instruction);
        else passed++;
    endtask

    task automatic test_pass_through;
        out_ready = 1'b0;
        offer(1'b1, 32'h0E0E_0E0E, 32'h30);
        tick;
        out_ready = 1'b1;
        offer(1'b1, 32'hF0F0_8001, 32'h34);
        tick;
        total++; if (occupancy !== 2'd1 || out_instruction !== 32'hF0F0_8001 || out_pc_plus4 !== 32'h34 || out_imm16 !== 16'h8001)
            $display("FAIL pass_through: occ=%0d inst=%h pc=%h imm=%h, want 1 f0f08001 00000034 8001", occupancy, out_instruction, out_pc_plus4, out_imm16);
        else passed++;
        offer(1'b0, 32'h0, 32'h0);
        tick;
        total++; if (occupancy !== 2'd0)
            $display("FAIL pass_drain: occ=%0d want 0", occupancy);
        else passed++;
    endtask

    task automatic test_random;
        ent_t q[$];
        logic r0, r1, acc, cons, bad;
        int shown = 0;
        for (int n = 0; n < 10000; n++) begin
            offer($urandom_range(0, 3) != 0, $urandom, $urandom);
            Flush = ($urandom_range(0, 31) == 0);
            out_ready = 1'b0;
            #1 r0 = in_ready;
            out_ready = 1'b1;
            #1 r1 = in_ready;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            total++;
            if (r0 !== r1 || r0 !== (q.size() < 2)) begin
                if (shown < 20) $display("FAIL rand_ready cyc %0d: rdy(or=0)=%b rdy(or=1)=%b, want %b", n, r0, r1, q.size() < 2);
                shown++;
            end else passed++;
            if (Flush) q.delete();
            else begin
                cons = (q.size() > 0) && out_ready;
                acc  = in_valid && (q.size() < 2);
                if (cons) void'(q.pop_front());
                if (acc) q.push_back('{i: in_instruction, p: in_pc_plus4});
            end
            tick;
            bad = (occupancy !== 2'(q.size())) || (out_valid !== (q.size() > 0));
            if (q.size() > 0)
                bad = bad || out_instruction !== q[0].i || out_pc_plus4 !== q[0].p || out_imm16 !== q[0].i[15:0];
            total++;
            if (bad) begin
                if (shown < 20) $display("FAIL rand_out cyc %0d: v=%b occ=%0d inst=%h pc=%h, want occ=%0d inst=%h pc=%h", n, out_valid, occupancy, out_instruction, out_pc_plus4, q.size(), q.size() > 0 ? q[0].i : 32'h0, q.size() > 0 ? q[0].p : 32'h0);
                shown++;
            end else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_flush;
        test_pass_through;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
